// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues word fetches, buffers returned words for decode.
// Optional macro IF_PERF_CNT_EN builds the fetch stall counter; otherwise fetch_stall_cnt is tied to 0.
module if_stage #(
   parameter int                  PC_WIDTH   = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter int                  FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req_valid,
   input  logic                imem_req_ready,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_rsp_valid,
   input  logic [31:0]         imem_rsp_data,
   input  logic                redirect_valid,
   input  logic [PC_WIDTH-1:0] redirect_pc,
   output logic                instr_valid,
   input  logic                id_ready,
   output logic [31:0]         instr_out,
   output logic [PC_WIDTH-1:0] pc_out,
   output logic [31:0]         fetch_stall_cnt
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [PC_WIDTH-1:0] pc;
   logic [CW-1:0]       outstanding;
   logic [CW-1:0]       drop_cnt;
   logic [CW-1:0]       fifo_count;
   logic [CW:0]         inflight;

   logic [PC_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
   logic [31:0]         fifo_data [FIFO_DEPTH];
   logic [PW-1:0]       fifo_rd;
   logic [PW-1:0]       fifo_wr;

   logic [PC_WIDTH-1:0] pcq [FIFO_DEPTH];
   logic [PW-1:0]       pcq_rd;
   logic [PW-1:0]       pcq_wr;

   logic req_fire;
   logic rsp_drop;
   logic rsp_owned;
   logic rsp_accept;
   logic pop;
   logic unused_pc_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Words still owed by memory plus words buffered must never exceed the buffer size.
   assign inflight       = {1'b0, outstanding} + {1'b0, fifo_count};
   assign imem_req_valid = rst_n && !redirect_valid && (inflight < (CW+1)'(FIFO_DEPTH));
   assign imem_addr      = pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
   assign rsp_owned      = imem_rsp_valid && ((drop_cnt != '0) || (outstanding != '0));
   assign rsp_accept     = imem_rsp_valid && (drop_cnt == '0) && (outstanding != '0) && !redirect_valid;

   assign instr_valid    = (fifo_count != '0);
   assign instr_out      = fifo_data[fifo_rd];
   assign pc_out         = fifo_pc[fifo_rd];
   assign pop            = instr_valid && id_ready;

   assign unused_pc_bits = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
      end else if (req_fire) begin
         pc <= pc + PC_WIDTH'(4);
      end
   end

   // On redirect every request still owed becomes a word to discard; a response landing
   // in the redirect cycle itself is one of those and is consumed right away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
         drop_cnt    <= '0;
      end else if (redirect_valid) begin
         outstanding <= '0;
         drop_cnt    <= drop_cnt + outstanding - CW'(rsp_owned);
      end else begin
         outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
         drop_cnt    <= drop_cnt - CW'(rsp_drop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcq_rd <= '0;
         pcq_wr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) pcq[i] <= '0;
      end else if (redirect_valid) begin
         pcq_rd <= '0;
         pcq_wr <= '0;
      end else begin
         if (req_fire) begin
            pcq[pcq_wr] <= pc;
            pcq_wr      <= ptr_inc(pcq_wr);
         end
         if (rsp_accept) pcq_rd <= ptr_inc(pcq_rd);
      end
   end

   // The credit rule guarantees a free slot whenever a response is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_rd    <= '0;
         fifo_wr    <= '0;
         fifo_count <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_pc[i]   <= '0;
            fifo_data[i] <= '0;
         end
      end else if (redirect_valid) begin
         fifo_rd    <= '0;
         fifo_wr    <= '0;
         fifo_count <= '0;
      end else begin
         if (rsp_accept) begin
            fifo_pc[fifo_wr]   <= pcq[pcq_rd];
            fifo_data[fifo_wr] <= imem_rsp_data;
            fifo_wr            <= ptr_inc(fifo_wr);
         end
         if (pop) fifo_rd <= ptr_inc(fifo_rd);
         fifo_count <= fifo_count + CW'(rsp_accept) - CW'(pop);
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_stall_cnt <= '0;
      end else if (id_ready && !instr_valid && (fetch_stall_cnt != 32'hFFFF_FFFF)) begin
         fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
      end
   end
`else
   assign fetch_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: fetch, backpressure, redirect/drop, PC wrap and stall counter.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        id_ready;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic [31:0] fetch_stall_cnt;

   int checks   = 0;
   int errors   = 0;
   int fire_cnt = 0;
   bit auto_mem = 1'b0;

   always #5 clk = ~clk;

   if_stage #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .instr_valid     (instr_valid),
      .id_ready        (id_ready),
      .instr_out       (instr_out),
      .pc_out          (pc_out),
      .fetch_stall_cnt (fetch_stall_cnt)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h8C01_0004;
         32'h0000_0004: return 32'hAC01_0008;
         default:       return 32'hC0DE_0000 | {16'h0000, a[15:0]};
      endcase
   endfunction

   // One clock: sample the handshake before the edge, then update the 1-cycle memory model.
   task automatic tick();
      logic        f;
      logic [31:0] a;
      #1;
      f = imem_req_valid && imem_req_ready;
      a = imem_addr;
      @(posedge clk);
      #1;
      if (f) fire_cnt++;
      if (auto_mem) begin
         imem_rsp_valid = f;
         imem_rsp_data  = f ? mem_word(a) : 32'h0;
      end
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_instr_valid: got %0b want 0", instr_valid); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid: got %0b want 0", imem_req_valid); end
      tick();
      tick();
      fire_cnt = 0;
      rst_n    = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      tick();
      checks++; if (instr_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr_out: got %h want 0", instr_out); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("[TB] FAIL rst_pc_out: got %h want 0", pc_out); end
      checks++; if (fetch_stall_cnt !== 32'h0) begin errors++; $display("[TB] FAIL rst_stall_cnt: got %0d want 0", fetch_stall_cnt); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_req_valid0: got %0b want 0", imem_req_valid); end
   endtask

   task automatic test_fetch();
      auto_mem       = 1'b1;
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      do_reset();
      checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_req0: got %0b want 1", imem_req_valid); end
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL fetch_addr0: got %h want 0", imem_addr); end
      tick();
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL fetch_addr1: got %h want 4", imem_addr); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_no_bypass: got %0b want 0", instr_valid); end
      tick();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("[TB] FAIL fetch_valid: got %0b want 1", instr_valid); end
      checks++; if (pc_out !== 32'h0) begin errors++; $display("[TB] FAIL fetch_pc0: got %h want 0", pc_out); end
      checks++; if (instr_out !== 32'h8C01_0004) begin errors++; $display("[TB] FAIL fetch_instr0: got %h want 8c010004", instr_out); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL fetch_credit: got %0b want 0", imem_req_valid); end
      tick();
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_req_valid[%0d]: got %0b want 0", i, imem_req_valid); end
         checks++; if (pc_out !== 32'h0 || instr_out !== 32'h8C01_0004) begin errors++; $display("[TB] FAIL bp_head[%0d]: got %h/%h want 0/8c010004", i, pc_out, instr_out); end
      end
      checks++; if (fire_cnt !== 2) begin errors++; $display("[TB] FAIL bp_fires: got %0d want 2", fire_cnt); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("[TB] FAIL bp_addr_hold: got %h want 8", imem_addr); end
      id_ready = 1'b1;
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h4 || instr_out !== 32'hAC01_0008) begin errors++; $display("[TB] FAIL drain_second: got %0b %h/%h want 1 4/ac010008", instr_valid, pc_out, instr_out); end
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty: got %0b want 0", instr_valid); end
   endtask

   task automatic test_redirect();
      auto_mem       = 1'b0;
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      do_reset();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_no_req: got %0b want 0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL redir_addr: got %0b %h want 1 00000100", imem_req_valid, imem_addr); end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_0000;
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop0: got %0b want 0", instr_valid); end
      imem_rsp_data = 32'hDEAD_0004;
      tick();
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_drop1: got %0b want 0", instr_valid); end
      imem_rsp_data = 32'h1111_0100;
      tick();
      imem_rsp_valid = 1'b0;
      checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instr_out !== 32'h1111_0100) begin errors++; $display("[TB] FAIL redir_first: got %0b %h/%h want 1 100/11110100", instr_valid, pc_out, instr_out); end
   endtask

   // Continues from test_redirect: one word buffered (0x100), one request (0x104) outstanding.
   task automatic test_redirect_collision();
      id_ready       = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h2222_0104;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      tick();
      imem_rsp_valid = 1'b0;
      redirect_pc    = 32'h0000_0303;
      #1;
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL coll_flush: got %0b want 0", instr_valid); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL coll_b2b_no_req: got %0b want 0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0000_0300) begin errors++; $display("[TB] FAIL coll_last_wins: got %0b %h want 1 00000300", imem_req_valid, imem_addr); end
      tick();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h3333_0300;
      tick();
      imem_rsp_valid = 1'b0;
      checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h300 || instr_out !== 32'h3333_0300) begin errors++; $display("[TB] FAIL coll_no_extra_drop: got %0b %h/%h want 1 300/33330300", instr_valid, pc_out, instr_out); end
   endtask

   task automatic test_back_to_back();
      auto_mem       = 1'b0;
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      do_reset();
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0400;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_addr !== 32'h0000_0400) begin errors++; $display("[TB] FAIL b2b_addr: got %h want 00000400", imem_addr); end
      for (int i = 0; i < 3; i++) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = 32'hBAD0_0000 + 32'(i);
         tick();
         checks++; if (instr_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drop[%0d]: got %0b want 0", i, instr_valid); end
      end
      imem_rsp_data = 32'h4444_0400;
      tick();
      imem_rsp_valid = 1'b0;
      checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h400 || instr_out !== 32'h4444_0400) begin errors++; $display("[TB] FAIL b2b_first: got %0b %h/%h want 1 400/44440400", instr_valid, pc_out, instr_out); end
   endtask

   task automatic test_pc_wrap();
      auto_mem       = 1'b0;
      imem_req_ready = 1'b1;
      id_ready       = 1'b0;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFF;
      tick();
      redirect_valid = 1'b0;
      #1;
      checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_top: got %0b %h want 1 fffffffc", imem_req_valid, imem_addr); end
      tick();
      checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_zero: got %h want 0", imem_addr); end
   endtask

   task automatic test_stall_cnt();
      logic [31:0] exp10;
      logic [31:0] exp11;
`ifdef IF_PERF_CNT_EN
      exp10 = 32'd10;
      exp11 = 32'd11;
`else
      exp10 = 32'd0;
      exp11 = 32'd0;
`endif
      auto_mem       = 1'b1;
      imem_req_ready = 1'b0;
      id_ready       = 1'b1;
      do_reset();
      checks++; if (fetch_stall_cnt !== 32'd0) begin errors++; $display("[TB] FAIL stall_reset: got %0d want 0", fetch_stall_cnt); end
      for (int i = 0; i < 10; i++) tick();
      checks++; if (fetch_stall_cnt !== exp10) begin errors++; $display("[TB] FAIL stall_10: got %0d want %0d", fetch_stall_cnt, exp10); end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0040;
      tick();
      redirect_valid = 1'b0;
      checks++; if (fetch_stall_cnt !== exp11) begin errors++; $display("[TB] FAIL stall_redirect: got %0d want %0d", fetch_stall_cnt, exp11); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_backpressure();
      test_redirect();
      test_redirect_collision();
      test_back_to_back();
      test_pc_wrap();
      test_stall_cnt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
